dc_chain_sched: RTL and testbench

// - Frame scheduler that time-shares one delay-commutator chain (DC 8/4/2/1, two samples/cycle) between two antenna streams.
// - Sits between the antenna sample sources and the chain; drives chain inputs and enable, and tags chain outputs with antenna/SOF/EOF.
// - Round-robin grant at frame boundaries; zero-flushes the chain tail when traffic stops.

---
 rtl/dc_chain_sched.sv | 146 ++++++++++++++
 tb/tb_dc_chain_sched.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dc_chain_sched.sv
// Frame scheduler sharing one delay-commutator chain between two antenna streams.
// Define DC_SCHED_FIXED_PRIO_EN for fixed priority (antenna 0 wins contested boundaries).
module dc_chain_sched #(
  parameter int DATA_WIDTH    = 16,
  parameter int FRAME_LEN     = 8,
  parameter int CHAIN_LATENCY = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a0_valid,
  output logic                  a0_ready,
  input  logic [DATA_WIDTH-1:0] a0_x0,
  input  logic [DATA_WIDTH-1:0] a0_x1,
  input  logic                  a1_valid,
  output logic                  a1_ready,
  input  logic [DATA_WIDTH-1:0] a1_x0,
  input  logic [DATA_WIDTH-1:0] a1_x1,
  output logic [DATA_WIDTH-1:0] chain_x0,
  output logic [DATA_WIDTH-1:0] chain_x1,
  output logic                  chain_en,
  input  logic [DATA_WIDTH-1:0] chain_y0,
  input  logic [DATA_WIDTH-1:0] chain_y1,
  output logic [DATA_WIDTH-1:0] out_y0,
  output logic [DATA_WIDTH-1:0] out_y1,
  output logic                  out_valid,
  output logic                  out_ant,
  output logic                  out_sof,
  output logic                  out_eof,
  output logic                  underrun,
  output logic                  busy
);

  localparam int BEAT_W  = $clog2(FRAME_LEN);
  localparam int FLUSH_W = $clog2(CHAIN_LATENCY + 1);
  localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(FRAME_LEN - 1);
  localparam logic [FLUSH_W-1:0] LAST_FLUSH = FLUSH_W'(CHAIN_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH
  } state_e;

  state_e               state_q;
  logic [BEAT_W-1:0]    beat_q;
  logic [FLUSH_W-1:0]   flush_cnt_q;
  logic                 grant_q;
  logic                 underrun_q;
  logic [3:0]           tag_q [CHAIN_LATENCY];
`ifndef DC_SCHED_FIXED_PRIO_EN
  logic                 last_grant_q;
`endif

  logic              req;
  logic              win;
  logic              start;
  logic              active;
  logic              cur_ant;
  logic              cur_valid;
  logic [BEAT_W-1:0] beat_cur;
  logic [3:0]        tag_in;

  // A frame may start from IDLE or FLUSH in the same cycle the request is seen.
  always_comb begin
    req = a0_valid | a1_valid;
`ifdef DC_SCHED_FIXED_PRIO_EN
    win = ~a0_valid;
`else
    win = (a0_valid && a1_valid) ? ~last_grant_q : ~a0_valid;
`endif
    start     = !reset && (state_q != STREAM) && req;
    active    = start || (!reset && (state_q == STREAM));
    cur_ant   = (state_q == STREAM) ? grant_q : win;
    cur_valid = cur_ant ? a1_valid : a0_valid;
    beat_cur  = (state_q == STREAM) ? beat_q : '0;
    tag_in    = {active, active & cur_ant,
                 active && (beat_cur == '0),
                 active && (beat_cur == LAST_BEAT)};
  end

  assign a0_ready = active && !cur_ant && a0_valid;
  assign a1_ready = active &&  cur_ant && a1_valid;
  assign chain_en = !reset && ((state_q != IDLE) || start);
  assign chain_x0 = (active && cur_valid) ? (cur_ant ? a1_x0 : a0_x0) : '0;
  assign chain_x1 = (active && cur_valid) ? (cur_ant ? a1_x1 : a0_x1) : '0;

  assign out_y0 = chain_y0;
  assign out_y1 = chain_y1;
  assign {out_valid, out_ant, out_sof, out_eof} = tag_q[CHAIN_LATENCY-1];
  assign underrun = underrun_q;
  assign busy     = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      flush_cnt_q <= '0;
      grant_q     <= 1'b0;
      underrun_q  <= 1'b0;
`ifndef DC_SCHED_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
      for (int i = 0; i < CHAIN_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      // Tags travel alongside the samples, so they only move when the chain does.
      if (chain_en) begin
        tag_q[0] <= tag_in;
        for (int i = 1; i < CHAIN_LATENCY; i++) tag_q[i] <= tag_q[i-1];
      end
      if (active && !cur_valid) underrun_q <= 1'b1;

      case (state_q)
        IDLE, FLUSH: begin
          if (start) begin
            state_q     <= STREAM;
            grant_q     <= win;
`ifndef DC_SCHED_FIXED_PRIO_EN
            last_grant_q <= win;
`endif
            beat_q      <= BEAT_W'(1);
            flush_cnt_q <= '0;
          end else if (state_q == FLUSH) begin
            if (flush_cnt_q == LAST_FLUSH) begin
              state_q     <= IDLE;
              flush_cnt_q <= '0;
            end else begin
              flush_cnt_q <= flush_cnt_q + 1'b1;
            end
          end
        end
        STREAM: begin
          // The cycle after the last beat arbitrates like FLUSH, giving gapless frames.
          if (beat_q == LAST_BEAT) begin
            state_q     <= FLUSH;
            beat_q      <= '0;
            flush_cnt_q <= '0;
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dc_chain_sched.sv
// Directed self-checking bench for dc_chain_sched with a plain enabled delay-line chain model.
// Honours DC_SCHED_FIXED_PRIO_EN for the contested-arbitration expectations.
module tb_dc_chain_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a0_valid = 1'b0, a1_valid = 1'b0;
  logic [15:0] a0_x0 = '0, a0_x1 = '0, a1_x0 = '0, a1_x1 = '0;
  logic        a0_ready, a1_ready, chain_en;
  logic [15:0] chain_x0, chain_x1, chain_y0, chain_y1, out_y0, out_y1;
  logic        out_valid, out_ant, out_sof, out_eof, underrun, busy;

  int tests = 0;
  int fails = 0;

  logic [15:0] m0 [15];
  logic [15:0] m1 [15];

  always #5 clk = ~clk;

  dc_chain_sched dut (
    .clk(clk), .reset(reset),
    .a0_valid(a0_valid), .a0_ready(a0_ready), .a0_x0(a0_x0), .a0_x1(a0_x1),
    .a1_valid(a1_valid), .a1_ready(a1_ready), .a1_x0(a1_x0), .a1_x1(a1_x1),
    .chain_x0(chain_x0), .chain_x1(chain_x1), .chain_en(chain_en),
    .chain_y0(chain_y0), .chain_y1(chain_y1),
    .out_y0(out_y0), .out_y1(out_y1),
    .out_valid(out_valid), .out_ant(out_ant), .out_sof(out_sof), .out_eof(out_eof),
    .underrun(underrun), .busy(busy)
  );

  // Chain stand-in: 15 enabled stages, cleared by reset.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) begin m0[i] <= '0; m1[i] <= '0; end
    end else if (chain_en) begin
      m0[0] <= chain_x0;
      m1[0] <= chain_x1;
      for (int i = 1; i < 15; i++) begin m0[i] <= m0[i-1]; m1[i] <= m1[i-1]; end
    end
  end
  assign chain_y0 = m0[14];
  assign chain_y1 = m1[14];

  task automatic set_in(input logic v0, input logic [15:0] d0, input logic v1, input logic [15:0] d1);
    a0_valid = v0; a0_x0 = d0; a0_x1 = d0 + 16'd1;
    a1_valid = v1; a1_x0 = d1; a1_x1 = d1 + 16'd1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    set_in(1'b0, 16'd0, 1'b0, 16'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    tests++; if (chain_en !== 1'b0) begin fails++; $display("[TB] FAIL reset_chain_en: got %0b expected 0", chain_en); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid); end
    tests++; if (underrun !== 1'b0) begin fails++; $display("[TB] FAIL reset_underrun: got %0b expected 0", underrun); end
    tests++; if ({a0_ready, a1_ready} !== 2'b00) begin fails++; $display("[TB] FAIL reset_ready: got %0b expected 00", {a0_ready, a1_ready}); end
  endtask

  task automatic test_single_frame();
    logic ev, eb;
    apply_reset();
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      set_in(c < 8, 16'(2*c + 1), 1'b0, 16'd0);
      #1;
      if (c < 8) begin
        tests++; if (a0_ready !== 1'b1) begin fails++; $display("[TB] FAIL single_ready cyc%0d: got %0b expected 1", c, a0_ready); end
        tests++; if (chain_x0 !== 16'(2*c + 1) || chain_x1 !== 16'(2*c + 2)) begin fails++;
          $display("[TB] FAIL single_chain_x cyc%0d: got %0d/%0d expected %0d/%0d", c, chain_x0, chain_x1, 2*c+1, 2*c+2); end
      end else begin
        tests++; if (a0_ready !== 1'b0) begin fails++; $display("[TB] FAIL single_ready_idle cyc%0d: got %0b expected 0", c, a0_ready); end
      end
      tests++; if (a1_ready !== 1'b0) begin fails++; $display("[TB] FAIL single_a1_ready cyc%0d: got %0b expected 0", c, a1_ready); end
      ev = (c >= 15 && c < 23);
      tests++; if (out_valid !== ev) begin fails++; $display("[TB] FAIL single_out_valid cyc%0d: got %0b expected %0b", c, out_valid, ev); end
      if (ev) begin
        tests++; if ({out_ant, out_sof, out_eof} !== {1'b0, c == 15, c == 22}) begin fails++;
          $display("[TB] FAIL single_tags cyc%0d: got %03b expected %03b", c, {out_ant, out_sof, out_eof}, {1'b0, c == 15, c == 22}); end
        tests++; if (out_y0 !== 16'(2*(c-15) + 1) || out_y1 !== 16'(2*(c-15) + 2)) begin fails++;
          $display("[TB] FAIL single_out_y cyc%0d: got %0d/%0d expected %0d/%0d", c, out_y0, out_y1, 2*(c-15)+1, 2*(c-15)+2); end
      end
      eb = (c >= 1 && c <= 22);
      tests++; if (busy !== eb) begin fails++; $display("[TB] FAIL single_busy cyc%0d: got %0b expected %0b", c, busy, eb); end
      tests++; if (chain_en !== (c <= 22)) begin fails++; $display("[TB] FAIL single_chain_en cyc%0d: got %0b expected %0b", c, chain_en, c <= 22); end
    end
  endtask

  task automatic test_back_to_back();
    logic ea, ev, oa;
    int   k;
    apply_reset();
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      set_in(c < 32, 16'(100 + c), c < 32, 16'(200 + c));
      #1;
`ifdef DC_SCHED_FIXED_PRIO_EN
      ea = 1'b0;
`else
      ea = ((c / 8) % 2) == 1;
`endif
      if (c < 32) begin
        tests++; if ({a0_ready, a1_ready} !== {~ea, ea}) begin fails++;
          $display("[TB] FAIL b2b_ready cyc%0d: got %02b expected %02b", c, {a0_ready, a1_ready}, {~ea, ea}); end
      end
      ev = (c >= 15 && c < 47);
      tests++; if (out_valid !== ev) begin fails++; $display("[TB] FAIL b2b_out_valid cyc%0d: got %0b expected %0b", c, out_valid, ev); end
      if (ev) begin
        k = c - 15;
`ifdef DC_SCHED_FIXED_PRIO_EN
        oa = 1'b0;
`else
        oa = ((k / 8) % 2) == 1;
`endif
        tests++; if ({out_ant, out_sof, out_eof} !== {oa, (k % 8) == 0, (k % 8) == 7}) begin fails++;
          $display("[TB] FAIL b2b_tags cyc%0d: got %03b expected %03b", c, {out_ant, out_sof, out_eof}, {oa, (k % 8) == 0, (k % 8) == 7}); end
        tests++; if (out_y0 !== 16'((oa ? 200 : 100) + k)) begin fails++;
          $display("[TB] FAIL b2b_out_y0 cyc%0d: got %0d expected %0d", c, out_y0, (oa ? 200 : 100) + k); end
      end
      tests++; if (busy !== (c >= 1 && c <= 46)) begin fails++; $display("[TB] FAIL b2b_busy cyc%0d: got %0b expected %0b", c, busy, c >= 1 && c <= 46); end
    end
  endtask

  task automatic test_underrun();
    logic ev;
    apply_reset();
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      set_in(c < 8 && c != 3, 16'(2*c + 1), 1'b0, 16'd0);
      #1;
      if (c == 3) begin
        tests++; if (chain_x0 !== 16'd0 || chain_x1 !== 16'd0) begin fails++;
          $display("[TB] FAIL underrun_zero_x: got %0d/%0d expected 0/0", chain_x0, chain_x1); end
        tests++; if (a0_ready !== 1'b0) begin fails++; $display("[TB] FAIL underrun_ready: got %0b expected 0", a0_ready); end
      end
      tests++; if (underrun !== (c >= 4)) begin fails++; $display("[TB] FAIL underrun_flag cyc%0d: got %0b expected %0b", c, underrun, c >= 4); end
      ev = (c >= 15 && c < 23);
      tests++; if (out_valid !== ev) begin fails++; $display("[TB] FAIL underrun_out_valid cyc%0d: got %0b expected %0b", c, out_valid, ev); end
      if (ev) begin
        tests++; if (out_y0 !== ((c == 18) ? 16'd0 : 16'(2*(c-15) + 1))) begin fails++;
          $display("[TB] FAIL underrun_out_y0 cyc%0d: got %0d expected %0d", c, out_y0, (c == 18) ? 0 : 2*(c-15)+1); end
        tests++; if ({out_sof, out_eof} !== {c == 15, c == 22}) begin fails++;
          $display("[TB] FAIL underrun_sof_eof cyc%0d: got %02b expected %02b", c, {out_sof, out_eof}, {c == 15, c == 22}); end
      end
    end
  endtask

  task automatic test_flush_abort();
    logic ev;
    int   last_eof = -1;
    int   gap = -1;
    apply_reset();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      set_in(c < 8, 16'(2*c + 1), c >= 13 && c < 21, 16'(50 + c));
      #1;
      if (c == 13) begin
        tests++; if ({busy, a1_ready, chain_x0} !== {1'b1, 1'b1, 16'd63}) begin fails++;
          $display("[TB] FAIL abort_accept: got busy=%0b rdy=%0b x0=%0d expected 1/1/63", busy, a1_ready, chain_x0); end
      end
      ev = (c >= 15 && c < 23) || (c >= 28 && c < 36);
      tests++; if (out_valid !== ev) begin fails++; $display("[TB] FAIL abort_out_valid cyc%0d: got %0b expected %0b", c, out_valid, ev); end
      if (ev) begin
        tests++; if (out_ant !== (c >= 28)) begin fails++; $display("[TB] FAIL abort_out_ant cyc%0d: got %0b expected %0b", c, out_ant, c >= 28); end
      end
      if (out_valid === 1'b1 && out_eof === 1'b1 && last_eof < 0) last_eof = c;
      if (out_valid === 1'b1 && out_sof === 1'b1 && last_eof >= 0 && gap < 0) gap = c - last_eof - 1;
      tests++; if (busy !== (c >= 1 && c <= 35)) begin fails++; $display("[TB] FAIL abort_busy cyc%0d: got %0b expected %0b", c, busy, c >= 1 && c <= 35); end
    end
    tests++; if (gap !== 5) begin fails++; $display("[TB] FAIL abort_gap: got %0d expected 5", gap); end
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      set_in(1'b1, 16'(300 + c), 1'b1, 16'(400 + c));
    end
    #1;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL midreset_pre_valid: got %0b expected 1", out_valid); end
    @(negedge clk);
    reset = 1'b1;
    set_in(1'b1, 16'd320, 1'b1, 16'd420);
    #1;
    tests++; if ({a0_ready, a1_ready, chain_en} !== 3'b000) begin fails++;
      $display("[TB] FAIL midreset_reset_wins: got %03b expected 000", {a0_ready, a1_ready, chain_en}); end
    @(negedge clk);
    reset = 1'b0;
    set_in(1'b0, 16'd0, 1'b0, 16'd0);
    #1;
    tests++; if ({out_valid, out_ant, out_sof, out_eof, underrun, busy, chain_en, a0_ready, a1_ready} !== 9'd0) begin fails++;
      $display("[TB] FAIL midreset_outputs: got %09b expected 000000000",
               {out_valid, out_ant, out_sof, out_eof, underrun, busy, chain_en, a0_ready, a1_ready}); end
    tests++; if ({chain_x0, out_y0} !== 32'd0) begin fails++; $display("[TB] FAIL midreset_data: got %0d/%0d expected 0/0", chain_x0, out_y0); end
    @(negedge clk);
    set_in(1'b1, 16'd500, 1'b1, 16'd600);
    #1;
    tests++; if ({a0_ready, a1_ready} !== 2'b10) begin fails++;
      $display("[TB] FAIL midreset_first_grant: got %02b expected 10", {a0_ready, a1_ready}); end
    @(negedge clk);
    set_in(1'b0, 16'd0, 1'b0, 16'd0);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_underrun();
    test_flush_abort();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
